// File: rtl/spi_master_param_pkg.sv
// Shared definitions for the parametrised SPI master: FSM states and a width helper.
package spi_master_param_pkg;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_XFER  = 3'd2,
    ST_TRAIL = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_t;

  // Bits needed to encode 'value' distinct items; never less than one.
  function automatic int f_clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// SCK half-period tick generator: one-cycle tick every div+1 cycles while enabled.
module spi_tick_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;

  assign tick = en & (r_cnt == {DIV_W{1'b0}});

  // Down-counter: preloads while disabled so the first tick lands exactly div+1 cycles after enable.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= {DIV_W{1'b0}};
    end else if (!en) begin
      r_cnt <= div;
    end else if (r_cnt == {DIV_W{1'b0}}) begin
      r_cnt <= div;
    end else begin
      r_cnt <= r_cnt - {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: configurable frame width, chip-select count, CPOL/CPHA and bit order.
// All mode/config inputs are captured when a frame is accepted; outputs are registered.
module spi_master_param
  import spi_master_param_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int NUM_CS = 1,
  parameter int DIV_W  = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       cpol,
  input  logic                       cpha,
  input  logic                       lsb_first,
  input  logic [DIV_W-1:0]           clk_div,
  input  logic [f_clog2(NUM_CS)-1:0] cs_sel,
  input  logic [DATA_W-1:0]          tx_data,
  output logic [DATA_W-1:0]          rx_data,
  output logic                       busy,
  output logic                       done,
  output logic                       sck,
  output logic                       mosi,
  output logic [NUM_CS-1:0]          cs_n,
  input  logic                       miso
);

  localparam int CS_W   = f_clog2(NUM_CS);
  localparam int EDGE_W = f_clog2(2 * DATA_W + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W);

  spi_state_t          r_state;
  logic                r_busy;
  logic                r_done;
  logic                r_sck;
  logic                r_mosi;
  logic [NUM_CS-1:0]   r_cs_n;
  logic [DATA_W-1:0]   r_rx_data;
  logic                r_cpol;
  logic                r_cpha;
  logic                r_lsb;
  logic                r_cs_ok;
  logic [DIV_W-1:0]    r_div;
  logic [DATA_W-1:0]   r_tx_sh;
  logic [DATA_W-1:0]   r_rx_sh;
  logic [EDGE_W-1:0]   r_edge;

  logic                w_tick;
  logic [DIV_W-1:0]    w_div;
  logic                w_cs_ok_in;
  logic [EDGE_W-1:0]   w_edge_nxt;
  logic                w_sample;

  // Bit that goes on the wire next for the chosen order.
  function automatic logic f_out_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  // Drop the bit just presented.
  function automatic logic [DATA_W-1:0] f_shift(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? {1'b0, v[DATA_W-1:1]} : {v[DATA_W-2:0], 1'b0};
  endfunction

  // Insert a received bit: at bit 0 for MSB-first, at the top for LSB-first.
  function automatic logic [DATA_W-1:0] f_rx_in(input logic [DATA_W-1:0] v, input logic lsb,
                                                input logic b);
    return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
  endfunction

  // One-hot-low select pattern; an out-of-range select leaves every line high.
  function automatic logic [NUM_CS-1:0] f_cs_decode(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] v;
    v = {NUM_CS{1'b1}};
    for (int i = 0; i < NUM_CS; i++) begin
      if (sel == CS_W'(i)) begin
        v[i] = 1'b0;
      end else begin
        v[i] = 1'b1;
      end
    end
    return v;
  endfunction

  // The divider follows the live input while idle so the accepted value is preloaded.
  assign w_div      = r_busy ? r_div : clk_div;
  assign w_cs_ok_in = (32'(cs_sel) < 32'(NUM_CS));
  assign w_edge_nxt = r_edge + {{(EDGE_W-1){1'b0}}, 1'b1};
  // cpha=0 samples on odd (leading) edges, cpha=1 on even (trailing) edges.
  assign w_sample   = w_edge_nxt[0] ^ r_cpha;

  spi_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (r_busy),
    .div     (w_div),
    .tick    (w_tick)
  );

  // Frame sequencer: state, shift registers, edge counter and all registered pins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sck     <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs_n    <= {NUM_CS{1'b1}};
      r_rx_data <= {DATA_W{1'b0}};
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_lsb     <= 1'b0;
      r_cs_ok   <= 1'b0;
      r_div     <= {DIV_W{1'b0}};
      r_tx_sh   <= {DATA_W{1'b0}};
      r_rx_sh   <= {DATA_W{1'b0}};
      r_edge    <= {EDGE_W{1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_LEAD;
            r_busy  <= 1'b1;
            r_cpol  <= cpol;
            r_cpha  <= cpha;
            r_lsb   <= lsb_first;
            r_div   <= clk_div;
            r_cs_ok <= w_cs_ok_in;
            r_cs_n  <= f_cs_decode(cs_sel);
            r_sck   <= cpol;
            r_edge  <= {EDGE_W{1'b0}};
            r_rx_sh <= {DATA_W{1'b0}};
            if (!cpha) begin
              // First bit must be valid before the first (sampling) edge.
              r_mosi  <= w_cs_ok_in & f_out_bit(tx_data, lsb_first);
              r_tx_sh <= f_shift(tx_data, lsb_first);
            end else begin
              r_mosi  <= 1'b0;
              r_tx_sh <= tx_data;
            end
          end else begin
            r_busy <= 1'b0;
            r_sck  <= r_cpol;
            r_mosi <= 1'b0;
            r_cs_n <= {NUM_CS{1'b1}};
          end
        end
        ST_LEAD: begin
          if (w_tick) begin
            r_state <= ST_XFER;
          end else begin
            r_state <= ST_LEAD;
          end
        end
        ST_XFER: begin
          if (w_tick) begin
            r_sck  <= ~r_sck;
            r_edge <= w_edge_nxt;
            if (w_sample) begin
              r_rx_sh <= f_rx_in(r_rx_sh, r_lsb, miso);
            end else if (w_edge_nxt != LAST_EDGE) begin
              r_mosi  <= r_cs_ok & f_out_bit(r_tx_sh, r_lsb);
              r_tx_sh <= f_shift(r_tx_sh, r_lsb);
            end else begin
              r_mosi <= r_mosi;
            end
            if (w_edge_nxt == LAST_EDGE) begin
              r_state <= ST_TRAIL;
            end else begin
              r_state <= ST_XFER;
            end
          end else begin
            r_state <= ST_XFER;
          end
        end
        ST_TRAIL: begin
          if (w_tick) begin
            r_state   <= ST_GAP;
            r_cs_n    <= {NUM_CS{1'b1}};
            r_mosi    <= 1'b0;
            r_done    <= 1'b1;
            r_rx_data <= r_rx_sh;
            r_sck     <= r_cpol;
          end else begin
            r_state <= ST_TRAIL;
          end
        end
        ST_GAP: begin
          if (w_tick) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_GAP;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_mosi  <= 1'b0;
          r_cs_n  <= {NUM_CS{1'b1}};
          r_sck   <= r_cpol;
        end
      endcase
    end
  end

  assign rx_data = r_rx_data;
  assign busy    = r_busy;
  assign done    = r_done;
  assign sck     = r_sck;
  assign mosi    = r_mosi;
  assign cs_n    = r_cs_n;

endmodule

// File: tb/tb_spi_master_param.sv
// Self-checking bench for spi_master_param: an 8-bit/3-select instance driven by directed and
// random frames against a behavioural SPI slave, plus a default 24-bit instance.
module tb_spi_master_param;

  localparam int N   = 8;
  localparam int NCS = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic           reset_n;
  logic           start, cpol, cpha, lsb_first;
  logic [7:0]     clk_div;
  logic [1:0]     cs_sel;
  logic [N-1:0]   tx_data, rx_data;
  logic           busy, done, sck, mosi, miso;
  logic [NCS-1:0] cs_n;
  logic           miso_drv, loopback;
  assign miso = loopback ? mosi : miso_drv;

  logic           start24, cpol24, cpha24, lsb24, miso24;
  logic [7:0]     clk_div24;
  logic [0:0]     cs_sel24;
  logic [23:0]    tx24, rx24;
  logic           busy24, done24, sck24, mosi24;
  logic [0:0]     cs24;
  assign miso24 = mosi24;

  spi_master_param #(.DATA_W(N), .NUM_CS(NCS), .DIV_W(8)) u_dut (
    .clock(clock), .reset_n(reset_n), .start(start), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb_first), .clk_div(clk_div), .cs_sel(cs_sel), .tx_data(tx_data),
    .rx_data(rx_data), .busy(busy), .done(done), .sck(sck), .mosi(mosi), .cs_n(cs_n),
    .miso(miso));

  spi_master_param u_dut24 (
    .clock(clock), .reset_n(reset_n), .start(start24), .cpol(cpol24), .cpha(cpha24),
    .lsb_first(lsb24), .clk_div(clk_div24), .cs_sel(cs_sel24), .tx_data(tx24),
    .rx_data(rx24), .busy(busy24), .done(done24), .sck(sck24), .mosi(mosi24), .cs_n(cs24),
    .miso(miso24));

  int vectors = 0;
  int errors  = 0;

  // Slave model configuration for the current frame.
  logic         m_cpol, m_cpha, m_lsb;
  logic [N-1:0] m_sword;

  // Observation state, owned by the monitor; cleared when clr_req changes.
  int clr_req = 0, clr_seen = 0, cyc = 0;
  int busy_cnt, done_cnt, done_at, edge_cnt, rise_cnt, low_run, low_last, hi_run, hi_last;
  int lead_t0, lead_t1, s_idx;
  int busy24_cnt, edge24_cnt, done24_cnt;
  logic [NCS-1:0] cs_and;
  logic cs_multi, mosi_bad, seen_low, cs_act, lead;
  logic p_busy = 1'b0, p_sck = 1'b0, p_cs_act = 1'b0, p_busy24 = 1'b0, p_sck24 = 1'b0;
  logic capq[$];

  function automatic logic sbit(input int k);
    return m_lsb ? m_sword[k] : m_sword[N-1-k];
  endfunction

  // Reassemble the word the slave captured, using the frame's bit order.
  function automatic logic [N-1:0] rebuild();
    logic [N-1:0] w;
    w = '0;
    for (int k = 0; k < capq.size() && k < N; k++) begin
      if (m_lsb) w[k] = capq[k];
      else       w[N-1-k] = capq[k];
    end
    return w;
  endfunction

  // Monitor and slave: sampled on the falling clock edge, away from DUT updates.
  always @(negedge clock) begin
    cyc = cyc + 1;
    if (clr_seen != clr_req) begin
      clr_seen = clr_req;
      busy_cnt = 0; done_cnt = 0; done_at = -1; edge_cnt = 0; rise_cnt = 0;
      low_run = 0; low_last = -1; hi_run = 0; hi_last = -1; lead_t0 = -1; lead_t1 = -1;
      cs_and = '1; cs_multi = 1'b0; mosi_bad = 1'b0; seen_low = 1'b0; capq.delete();
      busy24_cnt = 0; edge24_cnt = 0; done24_cnt = 0;
    end
    if (busy) begin
      if (done) done_at = busy_cnt;
      busy_cnt++;
    end
    if (done) done_cnt++;
    if (busy && !p_busy) begin
      rise_cnt++;
      if (rise_cnt > 1) low_last = low_run;
    end
    if (!busy) low_run++; else low_run = 0;
    cs_act = (cs_n != 3'b111);
    cs_and = cs_and & cs_n;
    if ($countones(~cs_n) > 1) cs_multi = 1'b1;
    if (!cs_act && mosi) mosi_bad = 1'b1;
    if (cs_act && !p_cs_act && seen_low) hi_last = hi_run;
    if (cs_act) seen_low = 1'b1;
    if (!cs_act) hi_run++; else hi_run = 0;
    if (cs_act && !p_cs_act) begin
      s_idx = 0;
      if (!m_cpha) begin miso_drv = sbit(0); s_idx = 1; end
    end
    if (busy && p_busy && (sck != p_sck)) begin
      edge_cnt++;
      lead = (sck != m_cpol);
      if (lead) begin
        if (lead_t0 < 0) lead_t0 = cyc;
        else if (lead_t1 < 0) lead_t1 = cyc;
      end
      if (cs_act) begin
        if (lead ^ m_cpha) capq.push_back(mosi);
        else if (s_idx < N) begin miso_drv = sbit(s_idx); s_idx++; end
      end
    end
    if (busy24) busy24_cnt++;
    if (done24) done24_cnt++;
    if (busy24 && p_busy24 && (sck24 != p_sck24)) edge24_cnt++;
    p_busy = busy; p_sck = sck; p_cs_act = cs_act; p_busy24 = busy24; p_sck24 = sck24;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_frame(input logic p_cpol, input logic p_cpha, input logic p_lsb,
                          input logic [7:0] p_div, input logic [1:0] p_cs,
                          input logic [N-1:0] p_tx, input logic [N-1:0] p_sw, input logic p_lb);
    @(posedge clock); #1;
    cpol = p_cpol; cpha = p_cpha; lsb_first = p_lsb; clk_div = p_div; cs_sel = p_cs;
    tx_data = p_tx; m_cpol = p_cpol; m_cpha = p_cpha; m_lsb = p_lsb; m_sword = p_sw;
    loopback = p_lb; miso_drv = 1'b0;
    clr_req++;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((busy !== 1'b0) && (n < budget)) begin
      @(negedge clock); #1;
      n++;
    end
    chk({tag, "_timeout"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_frame(input string tag, input int h, input logic valid,
                             input logic [1:0] p_cs, input logic [N-1:0] p_tx,
                             input logic [N-1:0] exp_rx);
    logic [2:0] one;
    one = 3'b001;
    chk({tag, "_busy_len"}, 32'(busy_cnt), 32'((2 * N + 3) * h));
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_done_at"},  32'(done_at),  32'((2 * N + 2) * h));
    chk({tag, "_edges"},    32'(edge_cnt), 32'(2 * N));
    chk({tag, "_cs"}, {29'd0, cs_and}, valid ? {29'd0, ~(one << p_cs)} : 32'h7);
    chk({tag, "_cs_multi"}, {31'd0, cs_multi}, 32'd0);
    chk({tag, "_mosi_idle"}, {31'd0, mosi_bad}, 32'd0);
    if (valid) begin
      chk({tag, "_mosi_bits"}, 32'(capq.size()), 32'(N));
      chk({tag, "_mosi_word"}, 32'(rebuild()), 32'(p_tx));
      chk({tag, "_rx"}, 32'(rx_data), 32'(exp_rx));
    end else begin
      chk({tag, "_mosi_bits"}, 32'(capq.size()), 32'd0);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish within 2 ms");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] tx, sw;
    logic         lb, c_pol, c_pha, c_lsb;
    logic [7:0]   dv;
    logic [1:0]   cs;
    int           n;

    reset_n = 1'b0; start = 1'b0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    clk_div = 8'd0; cs_sel = 2'd0; tx_data = '0; miso_drv = 1'b0; loopback = 1'b0;
    m_cpol = 1'b0; m_cpha = 1'b0; m_lsb = 1'b0; m_sword = '0;
    start24 = 1'b0; cpol24 = 1'b0; cpha24 = 1'b0; lsb24 = 1'b0; clk_div24 = 8'd0;
    cs_sel24 = 1'b0; tx24 = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_sck",  {31'd0, sck},  32'd0);
    chk("rst_mosi", {31'd0, mosi}, 32'd0);
    chk("rst_cs_n", {29'd0, cs_n}, 32'h7);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rx",   32'(rx_data),  32'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);

    // Mode 0, fastest SCK, loopback.
    do_frame(1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 8'hA5, 8'h00, 1'b1);
    wait_idle("t1", 100); #1;
    check_frame("t1", 1, 1'b1, 2'd0, 8'hA5, 8'hA5);

    // Mode 3, H=4, LSB first, slave answers 0x3C.
    do_frame(1'b1, 1'b1, 1'b1, 8'd3, 2'd0, 8'h01, 8'h3C, 1'b0);
    wait_idle("t2", 300); #1;
    check_frame("t2", 4, 1'b1, 2'd0, 8'h01, 8'h3C);
    chk("t2_first_mosi", {31'd0, capq.size() > 0 ? capq[0] : 1'b0}, 32'd1);
    chk("t2_sck_period", 32'(lead_t1 - lead_t0), 32'd8);
    repeat (3) @(negedge clock);
    #1;
    chk("t2_sck_idle", {31'd0, sck}, 32'd1);

    // Second select line.
    do_frame(1'b0, 1'b1, 1'b0, 8'd1, 2'd1, 8'h5E, 8'hC3, 1'b0);
    wait_idle("t5a", 200); #1;
    check_frame("t5a", 2, 1'b1, 2'd1, 8'h5E, 8'hC3);

    // Randomised frames against the slave model.
    for (int i = 0; i < 8; i++) begin
      c_pol = 1'($urandom_range(0, 1)); c_pha = 1'($urandom_range(0, 1));
      c_lsb = 1'($urandom_range(0, 1)); dv = 8'($urandom_range(0, 3));
      cs = 2'($urandom_range(0, 2)); tx = 8'($urandom); sw = 8'($urandom);
      lb = 1'($urandom_range(0, 1));
      do_frame(c_pol, c_pha, c_lsb, dv, cs, tx, sw, lb);
      wait_idle("rnd", 400); #1;
      check_frame("rnd", int'(dv) + 1, 1'b1, cs, tx, lb ? tx : sw);
    end

    // Start pulsed mid-frame is ignored.
    do_frame(1'b0, 1'b0, 1'b0, 8'd1, 2'd0, 8'h96, 8'h00, 1'b1);
    repeat (10) @(posedge clock);
    #1; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    wait_idle("t3a", 200);
    repeat (10) @(negedge clock);
    #1;
    chk("t3a_rises", 32'(rise_cnt), 32'd1);
    chk("t3a_dones", 32'(done_cnt), 32'd1);

    // Start held high: back-to-back frames with a minimum CS-high gap.
    @(posedge clock); #1;
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; clk_div = 8'd3; cs_sel = 2'd2;
    tx_data = 8'h3B; m_cpol = 1'b0; m_cpha = 1'b0; m_lsb = 1'b0; loopback = 1'b1;
    clr_req++;
    start = 1'b1;
    n = 0;
    while ((rise_cnt < 2) && (n < 400)) begin
      @(negedge clock); #1;
      n++;
    end
    chk("t3b_second_start", 32'(rise_cnt), 32'd2);
    @(posedge clock); #1; start = 1'b0;
    wait_idle("t3b", 400); #1;
    chk("t3b_dones", 32'(done_cnt), 32'd2);
    chk("t3b_cs_gap_ge4", {31'd0, hi_last >= 4}, 32'd1);
    chk("t3b_busy_gap", 32'(low_last), 32'd1);
    chk("t3b_rx", 32'(rx_data), 32'h3B);

    // Out-of-range select: full timing, no select, quiet MOSI.
    do_frame(1'b0, 1'b0, 1'b0, 8'd0, 2'd3, 8'hFF, 8'h00, 1'b0);
    wait_idle("t5b", 100); #1;
    check_frame("t5b", 1, 1'b0, 2'd3, 8'hFF, 8'h00);

    // Reset in the middle of a frame.
    do_frame(1'b0, 1'b0, 1'b0, 8'd3, 2'd0, 8'hE7, 8'h00, 1'b1);
    n = 0;
    while ((edge_cnt < 7) && (n < 200)) begin
      @(negedge clock); #1;
      n++;
    end
    chk("t4_reach_bit4", {31'd0, edge_cnt >= 7}, 32'd1);
    reset_n = 1'b0;
    @(posedge clock); #1;
    chk("t4_cs_n", {29'd0, cs_n}, 32'h7);
    chk("t4_sck",  {31'd0, sck},  32'd0);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_done", {31'd0, done}, 32'd0);
    chk("t4_mosi", {31'd0, mosi}, 32'd0);
    chk("t4_rx",   32'(rx_data),  32'd0);
    reset_n = 1'b1;
    repeat (60) @(negedge clock);
    #1;
    chk("t4_no_done", 32'(done_cnt), 32'd0);
    chk("t4_idle",    {31'd0, busy}, 32'd0);

    // Default 24-bit instance, H=8, loopback.
    @(posedge clock); #1;
    clk_div24 = 8'd7; tx24 = 24'hC0FFEE;
    clr_req++;
    start24 = 1'b1;
    @(posedge clock); #1; start24 = 1'b0;
    n = 0;
    while ((busy24 !== 1'b0) && (n < 2000)) begin
      @(negedge clock); #1;
      n++;
    end
    chk("t6_timeout", {31'd0, busy24}, 32'd0);
    chk("t6_busy_len", 32'(busy24_cnt), 32'd408);
    chk("t6_edges",    32'(edge24_cnt), 32'd48);
    chk("t6_dones",    32'(done24_cnt), 32'd1);
    chk("t6_rx",       32'(rx24),       32'h00C0FFEE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
